// File: rtl/dsp48_mac_seq_if.sv
// Job/operand/result handshake bundle between a host and the DSP48 MAC sequencer.
interface dsp48_mac_seq_if #(
  parameter int LEN_W = 8,
  parameter int P_W   = 48
);
  logic             start;
  logic [LEN_W-1:0] len;
  logic             busy;
  logic             in_valid;
  logic             in_ready;
  logic             res_valid;
  logic             res_ready;
  logic [P_W-1:0]   result;

  modport master (
    output start, len, in_valid, res_ready,
    input  busy, in_ready, res_valid, result
  );

  modport slave (
    input  start, len, in_valid, res_ready,
    output busy, in_ready, res_valid, result
  );
endinterface

// File: rtl/dsp48_mac_seq.sv
// Sequencer driving a DSP48A1 slice (AREG/BREG/MREG/PREG/OPMODEREG=1) through a
// dot-product job: one CE/OPMODE tag per accepted A/B pair, result captured from P.
module dsp48_mac_seq #(
  parameter int LEN_W = 8,
  parameter int P_W   = 48
) (
  input  logic                 clk,
  input  logic                 rstn,
  dsp48_mac_seq_if.slave       bus,
  output logic                 cea,
  output logic                 ceb,
  output logic                 cem,
  output logic                 cep,
  output logic                 ceopmode,
  output logic [7:0]           opmode,
  input  logic [P_W-1:0]       p_in
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, HOLD} state_t;

  state_t           state, state_d;
  logic [LEN_W-1:0] cnt, len_r;
  logic             in_ready_q;
  logic             v1, f1, v2;
  logic [P_W-1:0]   result_q;
  logic             acc, last;

  assign acc  = bus.in_valid & in_ready_q;
  assign last = (cnt == len_r - LEN_W'(1));

  assign bus.in_ready  = in_ready_q;
  assign bus.busy      = (state != IDLE);
  assign bus.res_valid = (state == HOLD);
  assign bus.result    = result_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_d;
  end

  // Stage 1 (v1/f1) times M and OPMODE loads, stage 2 (v2) times the P load.
  always_comb begin
    state_d  = state;
    cea      = acc;
    ceb      = acc;
    cem      = v1;
    ceopmode = v1;
    cep      = v2;
    opmode   = 8'h00;
    if (v1) opmode = f1 ? 8'h01 : 8'h09;
    case (state)
      IDLE:    if (bus.start) state_d = (bus.len != '0) ? RUN : HOLD;
      RUN:     if (acc && last) state_d = DRAIN;
      DRAIN:   if (!v1 && !v2) state_d = HOLD;
      HOLD:    if (bus.res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt        <= '0;
      len_r      <= '0;
      in_ready_q <= 1'b0;
      v1         <= 1'b0;
      f1         <= 1'b0;
      v2         <= 1'b0;
      result_q   <= '0;
    end else begin
      in_ready_q <= (state_d == RUN);
      v1         <= acc;
      f1         <= acc && (cnt == '0);
      v2         <= v1;
      case (state)
        IDLE: if (bus.start) begin
          cnt   <= '0;
          len_r <= bus.len;
          if (bus.len == '0) result_q <= '0;
        end
        RUN:   if (acc) cnt <= cnt + LEN_W'(1);
        // P settles the cycle after the last cep, which is when both tags are clear.
        DRAIN: if (state_d == HOLD) result_q <= p_in;
        default: ;
      endcase
    end
  end

endmodule
